// File: rtl/layernorm_bwd_stream_pkg.sv
// Shared types, default constants and the saturation helper for the
// LayerNorm backward streaming engine.
package ln_bwd_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    REDUCE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  localparam int DEF_EMBED_DIM = 8;
  localparam int LOG2_DIM      = $clog2(DEF_EMBED_DIM);
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC      = 8;
  localparam int DEF_ACC_W     = 48;

  // Wide enough for any intermediate the datapath saturates.
  localparam int SAT_IN_W = 64;

  // Clamp v to the signed range of a data_w-bit word; callers cast the result down.
  function automatic logic signed [SAT_IN_W-1:0] sat(input logic signed [SAT_IN_W-1:0] v,
                                                     input int data_w);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/layernorm_bwd_stream_if.sv
// Input beat stream (dy, xhat, gamma, rstd) and output dx stream, both valid/ready.
interface layernorm_bwd_stream_if
  import ln_bwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_dy;
  logic signed [DATA_W-1:0] in_xhat;
  logic signed [DATA_W-1:0] in_gamma;
  logic signed [DATA_W-1:0] in_rstd;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_dx;
  logic                     out_last;

  modport master (
    output in_valid, in_dy, in_xhat, in_gamma, in_rstd, out_ready,
    input  in_ready, out_valid, out_dx, out_last
  );

  modport slave (
    input  in_valid, in_dy, in_xhat, in_gamma, in_rstd, out_ready,
    output in_ready, out_valid, out_dx, out_last
  );
endinterface

// File: rtl/layernorm_bwd_stream_dx_datapath.sv
// Combinational dx = sat(((g - mean1 - (xhat*mean2 >>> FRAC)) * rstd) >>> FRAC),
// evaluated at ACC_W precision.
module ln_bwd_dx_datapath
  import ln_bwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic signed [DATA_W-1:0] g_i,
  input  logic signed [DATA_W-1:0] xhat_i,
  input  logic signed [DATA_W-1:0] rstd_i,
  input  logic signed [ACC_W-1:0]  mean1_i,
  input  logic signed [ACC_W-1:0]  mean2_i,
  output logic signed [DATA_W-1:0] dx_o
);

  logic signed [ACC_W-1:0] xhat_ext;
  logic signed [ACC_W-1:0] g_ext;
  logic signed [ACC_W-1:0] rstd_ext;
  logic signed [ACC_W-1:0] corr_prod;
  logic signed [ACC_W-1:0] corr;
  logic signed [ACC_W-1:0] centered;
  logic signed [ACC_W-1:0] scaled_prod;
  logic signed [ACC_W-1:0] scaled;

  assign xhat_ext    = ACC_W'(xhat_i);
  assign g_ext       = ACC_W'(g_i);
  assign rstd_ext    = ACC_W'(rstd_i);

  assign corr_prod   = xhat_ext * mean2_i;
  assign corr        = corr_prod >>> FRAC;
  assign centered    = g_ext - mean1_i - corr;
  assign scaled_prod = centered * rstd_ext;
  assign scaled      = scaled_prod >>> FRAC;

  assign dx_o = DATA_W'(sat(SAT_IN_W'(scaled), DATA_W));

endmodule

// File: rtl/layernorm_bwd_stream.sv
// Token-wise LayerNorm backward: buffers one token of (g, xhat), reduces the two
// means in a single cycle, then streams dx back out one element per handshake.
module layernorm_bwd_stream
  import ln_bwd_pkg::*;
#(
  parameter int EMBED_DIM = DEF_EMBED_DIM,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC      = DEF_FRAC,
  parameter int ACC_W     = DEF_ACC_W
) (
  input logic                   clk,
  input logic                   rst,
  layernorm_bwd_stream_if.slave bus
);

  localparam int LOG2_D = $clog2(EMBED_DIM);
  localparam int CNT_W  = LOG2_D;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EMBED_DIM - 1);

  localparam logic [1:0] ST_ACCUM  = ACCUM;
  localparam logic [1:0] ST_REDUCE = REDUCE;
  localparam logic [1:0] ST_EMIT   = EMIT;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  sum1_q, sum1_d;
  logic signed [ACC_W-1:0]  sum2_q, sum2_d;
  logic signed [ACC_W-1:0]  mean1_q, mean1_d;
  logic signed [ACC_W-1:0]  mean2_q, mean2_d;
  logic signed [DATA_W-1:0] rstd_q, rstd_d;

  logic signed [DATA_W-1:0] buf_g_q    [EMBED_DIM];
  logic signed [DATA_W-1:0] buf_xhat_q [EMBED_DIM];

  logic                     in_ready_w;
  logic                     out_valid_w;
  logic                     accept;
  logic                     out_fire;
  logic signed [ACC_W-1:0]  dyg_prod;
  logic signed [ACC_W-1:0]  dyg_shift;
  logic signed [DATA_W-1:0] g_new;
  logic signed [ACC_W-1:0]  g_new_ext;
  logic signed [ACC_W-1:0]  gx_prod;
  logic signed [ACC_W-1:0]  gx_term;
  logic signed [DATA_W-1:0] dx;

  assign in_ready_w  = (state_q == ST_ACCUM);
  assign out_valid_w = (state_q == ST_EMIT);
  assign accept      = bus.in_valid && in_ready_w;
  assign out_fire    = out_valid_w && bus.out_ready;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_last  = out_valid_w && (cnt_q == CNT_LAST);
  // Forced to zero outside EMIT so reset and idle never leak stale buffer data.
  assign bus.out_dx    = out_valid_w ? dx : '0;

  assign dyg_prod  = ACC_W'(bus.in_dy) * ACC_W'(bus.in_gamma);
  assign dyg_shift = dyg_prod >>> FRAC;
  assign g_new     = DATA_W'(sat(SAT_IN_W'(dyg_shift), DATA_W));
  assign g_new_ext = ACC_W'(g_new);
  assign gx_prod   = g_new_ext * ACC_W'(bus.in_xhat);
  assign gx_term   = gx_prod >>> FRAC;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum1_d  = sum1_q;
    sum2_d  = sum2_q;
    mean1_d = mean1_q;
    mean2_d = mean2_q;
    rstd_d  = rstd_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          // First beat loads the accumulators directly, so no clear cycle is needed.
          if (cnt_q == '0) begin
            sum1_d = g_new_ext;
            sum2_d = gx_term;
            rstd_d = bus.in_rstd;
          end else begin
            sum1_d = sum1_q + g_new_ext;
            sum2_d = sum2_q + gx_term;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_REDUCE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REDUCE: begin
        mean1_d = sum1_q >>> LOG2_D;
        mean2_d = sum2_q >>> LOG2_D;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_fire) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ACCUM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      sum1_q  <= '0;
      sum2_q  <= '0;
      mean1_q <= '0;
      mean2_q <= '0;
      rstd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum1_q  <= sum1_d;
      sum2_q  <= sum2_d;
      mean1_q <= mean1_d;
      mean2_q <= mean2_d;
      rstd_q  <= rstd_d;
    end
  end

  // Token buffer holds no reset: contents are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_g_q[cnt_q]    <= g_new;
      buf_xhat_q[cnt_q] <= bus.in_xhat;
    end
  end

  ln_bwd_dx_datapath #(
    .DATA_W(DATA_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_dx (
    .g_i    (buf_g_q[cnt_q]),
    .xhat_i (buf_xhat_q[cnt_q]),
    .rstd_i (rstd_q),
    .mean1_i(mean1_q),
    .mean2_i(mean2_q),
    .dx_o   (dx)
  );

endmodule

// File: tb/tb_layernorm_bwd_stream.sv
// Scoreboard bench: expected dx beats are queued when a token is driven and
// compared as the engine hands them out.
module tb_layernorm_bwd_stream;

  localparam int DIM = 8;
  localparam int DW  = 16;
  localparam int FR  = 8;
  localparam int AW  = 48;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layernorm_bwd_stream_if #(.DATA_W(DW)) bus ();

  layernorm_bwd_stream #(
    .EMBED_DIM(DIM),
    .DATA_W   (DW),
    .FRAC     (FR),
    .ACC_W    (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic signed [DW-1:0] dx;
    logic                 last;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hs     = 0;
  bit   bp_en    = 1'b0;
  bit   stalled  = 1'b0;
  logic signed [DW-1:0] hold_dx;
  logic signed [DW-1:0] tdy [DIM];
  logic signed [DW-1:0] txh [DIM];
  logic signed [DW-1:0] tgm [DIM];
  logic signed [DW-1:0] trs;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic push_expected();
    longint g [DIM];
    longint s1, s2, m1, m2, t;
    exp_t   e;
    s1 = 0;
    s2 = 0;
    for (int i = 0; i < DIM; i++) begin
      g[i] = sat16((longint'(tdy[i]) * longint'(tgm[i])) >>> FR);
      s1 += g[i];
      s2 += (g[i] * longint'(txh[i])) >>> FR;
    end
    m1 = s1 >>> $clog2(DIM);
    m2 = s2 >>> $clog2(DIM);
    for (int i = 0; i < DIM; i++) begin
      t      = g[i] - m1 - ((longint'(txh[i]) * m2) >>> FR);
      e.dx   = DW'(sat16((t * longint'(trs)) >>> FR));
      e.last = (i == DIM - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_token(input int n, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_dy    = tdy[i];
      bus.in_xhat  = txh[i];
      bus.in_gamma = tgm[i];
      bus.in_rstd  = (i == 0) ? trs : 16'sh7000;
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check("in_ready_timeout", 0, 1);
      @(posedge clk);
    end
    if (n == DIM) push_expected();
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (n == DIM) begin
      check("lat_valid_edge1", bus.out_valid, 0);
      check("lat_in_ready_edge1", bus.in_ready, 0);
      @(negedge clk);
      check("lat_valid_edge2", bus.out_valid, 1);
    end
    $display("token sent: %0d beats, gaps=%0d", n, gaps);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() > 0 || bus.out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("drain_timeout", sb.size(), 0);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
  endtask

  task automatic set_onehot();
    for (int i = 0; i < DIM; i++) begin
      tdy[i] = (i == 0) ? 16'sd256 : 16'sd0;
      tgm[i] = 16'sd256;
      txh[i] = 16'sd0;
    end
    trs = 16'sd256;
  endtask

  task automatic set_constant();
    tdy = '{default: 16'sd256};
    tgm = '{default: 16'sd256};
    txh = '{16'sd256, -16'sd256, 16'sd512, -16'sd512, 16'sd128, -16'sd128, 16'sd0, 16'sd0};
    trs = 16'sd256;
  endtask

  task automatic set_zero();
    for (int i = 0; i < DIM; i++) begin
      tdy[i] = 16'sd0;
      tgm[i] = 16'sd256;
      txh[i] = DW'(i * 37 - 100);
    end
    trs = 16'sd256;
  endtask

  // Output side: drives out_ready, checks stall stability and pops the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      stalled       = 1'b0;
      bus.out_ready = 1'b1;
    end else begin
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_dx", bus.out_dx, hold_dx);
      end
      bus.out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      stalled       = bus.out_valid && !bus.out_ready;
      hold_dx       = bus.out_dx;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("dx", bus.out_dx, e_mon.dx);
          check("last", bus.out_last, e_mon.last);
          n_hs++;
          $display("out beat: dx=%0d last=%0d (expected dx=%0d last=%0d)",
                   bus.out_dx, bus.out_last, e_mon.dx, e_mon.last);
        end
      end
    end
  end

  initial begin
    int t;
    int base;
    bus.in_valid  = 1'b0;
    bus.in_dy     = '0;
    bus.in_xhat   = '0;
    bus.in_gamma  = '0;
    bus.in_rstd   = '0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_dx", bus.out_dx, 0);
    check("rst_out_last", bus.out_last, 0);
    rst = 1'b0;

    set_zero();     send_token(DIM, 1'b0); wait_drain();
    set_constant(); send_token(DIM, 1'b0); wait_drain();
    set_onehot();   send_token(DIM, 1'b0); wait_drain();

    for (int i = 0; i < DIM; i++) begin
      tdy[i] = (i == 0) ? 16'sh7FFF : 16'sd0;
      tgm[i] = (i == 0) ? 16'sh7FFF : 16'sd256;
      txh[i] = 16'sd0;
    end
    trs = 16'sd256;
    send_token(DIM, 1'b0); wait_drain();

    // Backpressure plus junk input offered throughout EMIT.
    set_onehot();
    bp_en = 1'b1;
    send_token(DIM, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_dy    = 16'sh1111;
    bus.in_xhat  = 16'sh0222;
    bus.in_gamma = 16'sh0333;
    bus.in_rstd  = 16'sh2222;
    t = 0;
    while (!(bus.out_valid && bus.out_last) && t < 300) begin
      check("emit_in_ready", bus.in_ready, 0);
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("emit_last_timeout", 0, 1);
    bus.in_valid = 1'b0;
    wait_drain();
    bp_en = 1'b0;
    set_constant(); send_token(DIM, 1'b0); wait_drain();

    // Reset part-way through input accumulation.
    set_onehot();
    send_token(3, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midtok_rst_out_valid", bus.out_valid, 0);
    check("midtok_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send_token(DIM, 1'b0); wait_drain();

    // Reset during EMIT: remaining beats must never appear.
    set_onehot();
    base = n_hs;
    send_token(DIM, 1'b0);
    t = 0;
    while (n_hs < base + 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) check("emit_progress_timeout", n_hs, base + 4);
    #2;
    check("pre_rst_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("emit_rst_out_valid", bus.out_valid, 0);
    check("emit_rst_in_ready", bus.in_ready, 1);
    check("emit_rst_out_dx", bus.out_dx, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("emit_rst_no_resume", n_hs, base + 4);
    check("emit_rst_idle", bus.out_valid, 0);

    set_zero(); send_token(DIM, 1'b0); wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layernorm_bwd_stream.md
Name: layernorm_bwd_stream

Overview:
- Token-wise LayerNorm backward engine. It is the gradient-direction counterpart of the fused attention + LayerNorm forward path.
- Per token, it consumes one element per beat, each beat carrying the upstream gradient dy, the normalised activation xhat and gamma. It then emits the input gradient dx element by element.
- dx = rstd * (g - mean(g) - xhat * mean(g*xhat)), where g = dy*gamma.
- It sits between the training-mode gradient stream and the attention backward path.

Parameters:
- EMBED_DIM, 8, elements per token; must be a power of 2 and >= 2.
- DATA_W, 16, signed fixed-point width of all data ports.
- FRAC, 8, fractional bits (Q7.8 at defaults).
- ACC_W, 48, signed width of accumulators and intermediate products.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_dy  in  DATA_W  upstream gradient element, signed.
- in_xhat  in  DATA_W  normalised activation element, signed.
- in_gamma  in  DATA_W  LayerNorm scale element, signed.
- in_rstd  in  DATA_W  token reciprocal std, signed; sampled only on the first beat of a token.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_dx  out  DATA_W  input-gradient element, signed.
- out_last  out  1  high on the final (EMBED_DIM-th) output beat of a token.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high.
  - Async assert forces state ACCUM and clears element counter, sum1, sum2 and rstd_q.
  - Outputs during reset: in_ready=1, out_valid=0, out_dx=0, out_last=0.
  - Buffer contents are don't-care after reset.
  - A reset mid-token discards the partial token; no partial output is ever emitted.
- FSM states: ACCUM -> REDUCE -> EMIT -> ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Per accepted beat: g = sat_DATA_W((dy*gamma) >>> FRAC).
  - Store g and xhat in buf[cnt].
  - sum1 += g; sum2 += (g*xhat) >>> FRAC.
  - On beat cnt==0, latch rstd_q and load the accumulators with that beat's terms (no separate clear).
  - When the EMBED_DIM-th beat is accepted, go to REDUCE and reset cnt to 0.
- REDUCE (exactly 1 cycle):
  - in_ready=0, out_valid=0.
  - mean1 = sum1 >>> log2(EMBED_DIM); mean2 = sum2 >>> log2(EMBED_DIM).
  - Register both means; go to EMIT.
- EMIT:
  - in_ready=0; out_valid=1.
  - out_dx = sat_DATA_W(((buf_g[cnt] - mean1 - ((buf_xhat[cnt]*mean2) >>> FRAC)) * rstd_q) >>> FRAC).
  - out_dx is computed in ACC_W. The output is registered or combinational from registered state; either way it must be stable while out_valid && !out_ready.
  - cnt advances only on out_valid && out_ready.
  - out_last = (cnt == EMBED_DIM-1).
  - Handshake of the last beat: return to ACCUM with cnt=0; in_ready rises the next cycle.
- Timing:
  - Latency from last input accept to first out_valid: 1 cycle (the REDUCE cycle), so out_valid is high 2 edges after the final input accept.
  - Token period with no backpressure: 2*EMBED_DIM + 1 cycles.
  - No input/output overlap.
- Arithmetic:
  - All shifts are arithmetic (floor toward -inf).
  - sat_DATA_W clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - No rounding.
- Boundaries:
  - in_valid while in_ready=0: ignored, no state change.
  - in_valid toggling mid-token: the counter counts only handshakes.
  - out_ready held low indefinitely: hold the current beat, no loss.
  - Counter wraps only via FSM transition, never past EMBED_DIM-1.

Decomposition:
- Package ln_bwd_pkg holds:
  - state enum {ACCUM, REDUCE, EMIT};
  - localparam LOG2_DIM;
  - a sat function parameterised on DATA_W;
  - the FRAC default constant.
- One sub-module, ln_bwd_dx_datapath: purely combinational dx computation from (g, xhat, mean1, mean2, rstd) to sat out_dx.
- The FSM, buffer and accumulators stay in the top level.

Test Plan:
- Zero gradient: rstd=256; all dy=0, gamma=256, arbitrary xhat.
  - Expected: 8 beats of dx=0, out_last on beat 8 only; first out_valid 2 edges after the final input accept.
- Constant gradient: rstd=256; dy=256, gamma=256, xhat={256,-256,512,-512,128,-128,0,0} (sum 0).
  - Expected: g=256, mean1=256, mean2=0, all dx=0.
- One-hot gradient: rstd=256; dy={256,0,...,0}, gamma=256, xhat=0.
  - Expected: dx={224,-32,-32,-32,-32,-32,-32,-32}.
- Saturation: dy0=gamma0=0x7FFF, other dy=0, gamma=256, xhat=0, rstd=256.
  - Expected: g0=32767, mean1=4095, dx={28672,-4095 x7}.
- Backpressure: one-hot case above with out_ready toggling 1-0-0-1 randomly; also drive in_valid during EMIT.
  - Expected: identical dx sequence, out_dx stable while stalled, extra inputs not accepted, in_ready=0 until after the last output handshake.
- Reset mid-token:
  - Assert rst after 3 input beats. Expected: out_valid=0 immediately (async) and in_ready=1.
  - Then run the one-hot token. Expected: dx exactly as the one-hot case above.
  - Also assert rst during EMIT beat 4. Expected: the remaining beats are never emitted.
